dual_edge_logic_pipe: RTL and testbench

- Parametrised, multi-channel successor to the team's dual-edge logic cell.
- Stage 1 computes a selectable bitwise op of inputs a/b on the falling clock edge. Stage 2 combines that result with b on the rising edge.
- Adds valid/ready flow control, per-transaction op selection, output stall/hold and a transfer counter.
- Sits between a producer and a consumer as a half-cycle-split logic pipeline; fully synthesizable, no intra-assignment delays.

---
 rtl/dual_edge_logic_pipe_if.sv | 29 ++
 rtl/dual_edge_logic_pipe.sv | 143 ++++++++++++++
 tb/tb_dual_edge_logic_pipe.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dual_edge_logic_pipe_if.sv
// Handshake and data bus for dual_edge_logic_pipe: producer side (in_*, a, b, op selects)
// and consumer side (out_*, f, g, xfer_cnt).
interface dual_edge_logic_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned CNT_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*WIDTH-1:0]   a;
  logic [CH*WIDTH-1:0]   b;
  logic [1:0]            op1_sel;
  logic [1:0]            op2_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*WIDTH-1:0]   f;
  logic [CH*WIDTH-1:0]   g;
  logic [CNT_W-1:0]      xfer_cnt;

  modport master (
    output in_valid, a, b, op1_sel, op2_sel, out_ready,
    input  in_ready, out_valid, f, g, xfer_cnt
  );

  modport slave (
    input  in_valid, a, b, op1_sel, op2_sel, out_ready,
    output in_ready, out_valid, f, g, xfer_cnt
  );
endinterface

// File: rtl/dual_edge_logic_pipe.sv
// Half-cycle-split logic pipeline: stage 1 (op1 of a,b) on the falling edge,
// stage 2 (op2 of f,b) on the rising edge, with valid/ready flow control and a transfer counter.
module dual_edge_logic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_edge_logic_pipe_if.slave bus
);
  localparam int unsigned W = WIDTH * CH;

  typedef enum logic [1:0] {
    OP_OR   = 2'd0,
    OP_AND  = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

  function automatic logic [W-1:0] apply_op(input op_e op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      case (op)
        OP_OR:   r[c*WIDTH +: WIDTH] = x[c*WIDTH +: WIDTH] | y[c*WIDTH +: WIDTH];
        OP_AND:  r[c*WIDTH +: WIDTH] = x[c*WIDTH +: WIDTH] & y[c*WIDTH +: WIDTH];
        OP_XOR:  r[c*WIDTH +: WIDTH] = x[c*WIDTH +: WIDTH] ^ y[c*WIDTH +: WIDTH];
        default: r[c*WIDTH +: WIDTH] = ~(x[c*WIDTH +: WIDTH] ^ y[c*WIDTH +: WIDTH]);
      endcase
    end
    return r;
  endfunction

  // Rising-edge state
  logic [W-1:0]     a_q, a_d, b_q, b_d, g_q, g_d;
  op_e              op1_q, op1_d, op2_q, op2_d;
  logic             front_valid_q, front_valid_d;
  logic             acc_tog_q, acc_tog_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Falling-edge state
  logic [W-1:0]     f_q, f_d, bf_q, bf_d;
  logic             done_tog_q, done_tog_d;

  logic f_done, out_free, in_ready, accept, front_move, consume;

  // f_done is "set on negedge, cleared on posedge"; a toggle pair keeps each flop
  // owned by a single edge: acceptance flips acc_tog, stage 1 copies it into done_tog.
  assign f_done     = (acc_tog_q == done_tog_q);
  assign out_free   = !out_valid_q || bus.out_ready;
  assign in_ready   = !front_valid_q || out_free;
  assign accept     = bus.in_valid && in_ready;
  assign front_move = front_valid_q && f_done && out_free;
  assign consume    = out_valid_q && bus.out_ready;

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    front_valid_d = front_valid_q;
    acc_tog_d     = acc_tog_q;
    g_d           = g_q;
    out_valid_d   = out_valid_q;
    cnt_d         = cnt_q;

    if (accept) begin
      a_d           = bus.a;
      b_d           = bus.b;
      op1_d         = op_e'(bus.op1_sel);
      op2_d         = op_e'(bus.op2_sel);
      front_valid_d = 1'b1;
      acc_tog_d     = ~acc_tog_q;
    end else if (front_move) begin
      front_valid_d = 1'b0;
    end

    if (front_move) begin
      g_d         = apply_op(op2_q, f_q, bf_q);
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    if (consume) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      op1_q         <= OP_OR;
      op2_q         <= OP_OR;
      front_valid_q <= 1'b0;
      acc_tog_q     <= 1'b0;
      g_q           <= '0;
      out_valid_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      front_valid_q <= front_valid_d;
      acc_tog_q     <= acc_tog_d;
      g_q           <= g_d;
      out_valid_q   <= out_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    f_d        = f_q;
    bf_d       = bf_q;
    done_tog_d = done_tog_q;
    if (front_valid_q && !f_done) begin
      f_d        = apply_op(op1_q, a_q, b_q);
      bf_d       = b_q;
      done_tog_d = acc_tog_q;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q        <= '0;
      bf_q       <= '0;
      done_tog_q <= 1'b0;
    end else begin
      f_q        <= f_d;
      bf_q       <= bf_d;
      done_tog_q <= done_tog_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.g         = g_q;
  assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_dual_edge_logic_pipe.sv
// Scoreboard bench for dual_edge_logic_pipe: directed vectors push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_dual_edge_logic_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned W     = WIDTH * CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_edge_logic_pipe_if #(.WIDTH(WIDTH), .CH(CH), .CNT_W(CNT_W)) bus ();

  dual_edge_logic_pipe #(.WIDTH(WIDTH), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  logic [W-1:0] op1_exp [4] = '{16'h0F0F, 16'h0A0A, 16'h0505, 16'h0A0A};
  logic [W-1:0] op2_exp [4] = '{16'hAFAF, 16'h0505, 16'hAAAA, 16'h5555};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // Monitor: a handshake seen here completes at the following posedge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n !== 1'b1) begin
      exp_cnt = '0;
    end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got g=%h, required no output", bus.g);
      end else begin
        chk("g_scoreboard", 32'(bus.g), 32'(exp_q.pop_front()));
      end
      chk("xfer_cnt_model", 32'(bus.xfer_cnt), 32'(exp_cnt));
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] o1,
                      input logic [1:0] o2, input logic [W-1:0] expv, output int waits);
    bit acc;
    bit done;
    bus.a        = av;
    bus.b        = bv;
    bus.op1_sel  = o1;
    bus.op2_sel  = o2;
    bus.in_valid = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(expv);
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept in 50 cycles, required accept");
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op1_sel   = 2'd0;
    bus.op2_sel   = 2'd0;
    bus.out_ready = 1'b1;

    // Reset state
    idle(2);
    chk("rst_f", 32'(bus.f), 32'h0);
    chk("rst_g", 32'(bus.g), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'h1);

    // Single transaction: OR then XOR
    send(16'h0FF0, 16'h3355, 2'd0, 2'd2, 16'h0CA0, w);
    @(negedge clk);
    #1;
    chk("single_f", 32'(bus.f), 32'h3FF5);
    @(posedge clk);
    #1;
    chk("single_g", 32'(bus.g), 32'h0CA0);
    chk("single_out_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #1;
    chk("single_xfer_cnt", 32'(bus.xfer_cnt), 32'h1);
    chk("single_drained", 32'(bus.out_valid), 32'h0);

    // Op coverage
    for (int i = 0; i < 4; i++) send(16'hAAAA, 16'h0F0F, 2'(i), 2'd1, op1_exp[i], w);
    for (int i = 0; i < 4; i++) send(16'hAAAA, 16'h0F0F, 2'd2, 2'(i), op2_exp[i], w);
    idle(3);

    // Backpressure
    bus.out_ready = 1'b0;
    fork
      begin
        send(16'h1234, 16'h00FF, 2'd2, 2'd0, 16'h12FF, w);
        send(16'hFFFF, 16'h0F0F, 2'd1, 2'd3, 16'hFFFF, w);
        send(16'h0000, 16'h8001, 2'd0, 2'd2, 16'h0000, w);
        chk("bp_in_ready_dropped", 32'(w > 0), 32'h1);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_g_hold", 32'(bus.g), 32'h12FF);
        chk("bp_out_valid_hold", 32'(bus.out_valid), 32'h1);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(4);

    // Async reset half a cycle after an accept
    send(16'h0FF0, 16'h3355, 2'd0, 2'd2, 16'h0CA0, w);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_f", 32'(bus.f), 32'h0);
    chk("arst_g", 32'(bus.g), 32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("arst_no_result", 32'(bus.out_valid), 32'h0);

    // Streaming: XOR then XOR with the same b returns a
    for (int i = 0; i < 10; i++) begin
      send(16'(16'h1111 * i), 16'hA5C3, 2'd2, 2'd2, 16'(16'h1111 * i), w);
      chk("stream_in_ready", 32'(w), 32'h0);
    end
    idle(3);
    chk("stream_xfer_cnt", 32'(bus.xfer_cnt), 32'd10);

    // Counter wrap at 4 bits: 17 handshakes since reset
    for (int i = 0; i < 7; i++) send(16'h0101, 16'h0000, 2'd0, 2'd0, 16'h0101, w);
    idle(3);
    chk("wrap_xfer_cnt", 32'(bus.xfer_cnt), 32'h1);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
